// File: rtl/frame_uplink_if.sv
// Frame-stream and host byte-stream bundle for frame_uplink.
// master is the uplink itself; slave is the surrounding source/sink.
interface frame_uplink_if;
   logic        frame_ready;
   logic [15:0] frame_size;
   logic [31:0] in_data;
   logic        in_vld;
   logic        in_rdy;
   logic [7:0]  byte_data;
   logic        byte_vld;
   logic        byte_rdy;
   logic        busy;
   logic [15:0] frame_cnt;
   logic        timeout;
   logic        clamped;

   modport master (
      input  frame_ready, frame_size, in_data, in_vld, byte_rdy,
      output in_rdy, byte_data, byte_vld, busy, frame_cnt,
             timeout, clamped
   );

   modport slave (
      output frame_ready, frame_size, in_data, in_vld, byte_rdy,
      input  in_rdy, byte_data, byte_vld, busy, frame_cnt,
             timeout, clamped
   );
endinterface

// File: rtl/frame_uplink.sv
// Drains a completed frame and serializes it as header + payload bytes.
// Define FRAME_UPLINK_SUM_EN to append a 32-bit payload sum trailer.
module frame_uplink #(
   parameter logic [31:0] SYNC_WORD = 32'hA5C3_5A3C,
   parameter logic [15:0] MAX_WORDS = 16'd4096,
   parameter logic [15:0] TIMEOUT   = 16'd1000
) (
   input  logic           sys_clk,
   input  logic           rst_n,
   frame_uplink_if.master bus
);

`ifdef FRAME_UPLINK_SUM_EN
   typedef enum logic [2:0] {
      IDLE, HDR, LOAD, SEND, DISCARD, SUM, DONE
   } state_t;
   localparam state_t TAIL = SUM;
`else
   typedef enum logic [2:0] {
      IDLE, HDR, LOAD, SEND, DISCARD, DONE
   } state_t;
   localparam state_t TAIL = DONE;
`endif

   state_t      state;
   state_t      state_nxt;
   logic        armed;
   logic [15:0] len;
   logic [15:0] extra;
   logic [15:0] remain;
   logic [15:0] cnt;
   logic        busy;
   logic        timeout;
   logic        clamped;
   logic        pad;
   logic [15:0] idle;
   logic [31:0] word;
   logic [2:0]  bidx;
`ifdef FRAME_UPLINK_SUM_EN
   logic [31:0] sum;
`endif

   logic        in_rdy;
   logic        byte_vld;
   logic [7:0]  byte_data;
   logic        start;
   logic        hs_byte;
   logic        idle_hit;
   logic        hdr_last;
   logic        word_last;
   logic [15:0] len_in;
   logic [63:0] hdr;
   state_t      after_hdr;
   state_t      after_word;

   assign start    = armed & bus.frame_ready;
   assign hs_byte  = byte_vld & bus.byte_rdy;
   assign idle_hit = (idle == TIMEOUT - 16'd1) & ~bus.in_vld;
   assign hdr_last = (bidx == 3'd7);
   assign word_last = (bidx[1:0] == 2'd3);
   assign len_in   = (bus.frame_size > MAX_WORDS) ? MAX_WORDS
                                                  : bus.frame_size;
   assign hdr      = {cnt, len, SYNC_WORD};

   assign after_hdr = (len != 16'd0)   ? LOAD :
                      (extra != 16'd0) ? DISCARD : TAIL;

   // pad mode never re-opens the input: zeros go straight to SEND
   assign after_word = (remain > 16'd1) ? (pad ? SEND : LOAD) :
                       ((extra != 16'd0) && !pad) ? DISCARD : TAIL;

   always_ff @(posedge sys_clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_rdy    = 1'b0;
      byte_vld  = 1'b0;
      byte_data = 8'h00;
      case (state)
         IDLE: begin
            if (start) state_nxt = HDR;
         end
         HDR: begin
            byte_vld  = 1'b1;
            byte_data = hdr[{bidx, 3'b000} +: 8];
            if (hs_byte && hdr_last) state_nxt = after_hdr;
         end
         LOAD: begin
            in_rdy = 1'b1;
            if (bus.in_vld || idle_hit) state_nxt = SEND;
         end
         SEND: begin
            byte_vld  = 1'b1;
            byte_data = word[{bidx[1:0], 3'b000} +: 8];
            if (hs_byte && word_last) state_nxt = after_word;
         end
         DISCARD: begin
            in_rdy = 1'b1;
            if ((bus.in_vld && extra == 16'd1) || idle_hit)
               state_nxt = TAIL;
         end
`ifdef FRAME_UPLINK_SUM_EN
         SUM: begin
            byte_vld  = 1'b1;
            byte_data = sum[{bidx[1:0], 3'b000} +: 8];
            if (hs_byte && word_last) state_nxt = DONE;
         end
`endif
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         armed   <= 1'b0;
         len     <= '0;
         extra   <= '0;
         remain  <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         timeout <= 1'b0;
         clamped <= 1'b0;
         pad     <= 1'b0;
         idle    <= '0;
         word    <= '0;
         bidx    <= '0;
`ifdef FRAME_UPLINK_SUM_EN
         sum     <= '0;
`endif
      end else begin
         if (!bus.frame_ready) armed <= 1'b1;
         case (state)
            IDLE: begin
               if (start) begin
                  len   <= len_in;
                  extra <= bus.frame_size - len_in;
                  armed <= 1'b0;
                  cnt   <= cnt + 16'd1;
                  busy  <= 1'b1;
                  pad   <= 1'b0;
                  idle  <= '0;
                  bidx  <= '0;
                  if (bus.frame_size > MAX_WORDS) clamped <= 1'b1;
`ifdef FRAME_UPLINK_SUM_EN
                  sum   <= '0;
`endif
               end
            end
            HDR: begin
               if (hs_byte) begin
                  bidx <= hdr_last ? 3'd0 : bidx + 3'd1;
                  if (hdr_last) begin
                     remain <= len;
                     idle   <= '0;
                  end
               end
            end
            LOAD: begin
               if (bus.in_vld) begin
                  word <= bus.in_data;
                  idle <= '0;
               end else if (idle_hit) begin
                  word    <= '0;
                  pad     <= 1'b1;
                  timeout <= 1'b1;
                  idle    <= '0;
               end else begin
                  idle <= idle + 16'd1;
               end
            end
            SEND: begin
               if (hs_byte) begin
                  bidx <= word_last ? 3'd0 : bidx + 3'd1;
                  if (word_last) begin
                     remain <= remain - 16'd1;
                     idle   <= '0;
`ifdef FRAME_UPLINK_SUM_EN
                     sum    <= sum + word;
`endif
                  end
               end
            end
            DISCARD: begin
               if (bus.in_vld) begin
                  extra <= extra - 16'd1;
                  idle  <= '0;
               end else if (idle_hit) begin
                  timeout <= 1'b1;
               end else begin
                  idle <= idle + 16'd1;
               end
            end
`ifdef FRAME_UPLINK_SUM_EN
            SUM: begin
               if (hs_byte) bidx <= word_last ? 3'd0 : bidx + 3'd1;
            end
`endif
            DONE: busy <= 1'b0;
            default: ;
         endcase
      end
   end

   assign bus.in_rdy    = in_rdy;
   assign bus.byte_vld  = byte_vld;
   assign bus.byte_data = byte_data;
   assign bus.busy      = busy;
   assign bus.frame_cnt = cnt;
   assign bus.timeout   = timeout;
   assign bus.clamped   = clamped;

endmodule
